// File: rtl/xc_rf_wb_ctrl.sv
// xc_rf_wb_ctrl: write-side producer for the forwarding 3-read register file.
// It merges execute results and long-latency (load/coprocessor) returns into
// a 3-stage writeback pipeline S0 -> S1 -> S2. It also keeps a pending-write
// scoreboard that the issue stage uses to stall on unproduced sources.
//
// Handshake: an execute result transfers on a rising edge where
// ex_valid && ex_ready. ex_ready is combinational and drops whenever
// lsu_valid is high, because the long-latency return cannot be stalled and
// always wins the S0 slot. pend_set transfers when pend_ready is high, and is
// otherwise ignored. lsu_valid has no ready; it is always taken.
module xc_rf_wb_ctrl #(
  parameter int MAX_PEND = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wen,
  input  logic [4:0]  ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        pend_set,
  input  logic [4:0]  pend_addr,
  output logic        pend_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rs3_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rs3_busy,
  output logic        fwd_0_wen,
  output logic [4:0]  fwd_0_addr,
  output logic [31:0] fwd_0_wdata,
  output logic        fwd_1_wen,
  output logic [4:0]  fwd_1_addr,
  output logic [31:0] fwd_1_wdata,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        pend_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PEND);

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } stage_t;

  stage_t      s0, s1, s2, s0_next;
  logic [31:0] pend_mask, mask_next;
  logic [3:0]  pend_cnt, cnt_next;
  logic        set_en;
  logic        lsu_err;

  assign ex_ready   = !lsu_valid;
  assign pend_ready = (pend_cnt < MAX_CNT);
  assign set_en     = pend_set && pend_ready && (pend_addr != 5'd0);
  // A return with nothing outstanding, or for a register not marked pending.
  assign lsu_err    = lsu_valid && ((pend_cnt == 4'd0) || !pend_mask[lsu_addr]);

  // S0 entry arbitration: the LSU return first, then an execute write; x0 never becomes valid.
  always_comb begin
    s0_next = '0;
    if (lsu_valid) begin
      s0_next.valid = (lsu_addr != 5'd0);
      s0_next.addr  = lsu_addr;
      s0_next.data  = lsu_wdata;
    end else if (ex_valid && ex_wen) begin
      s0_next.valid = (ex_addr != 5'd0);
      s0_next.addr  = ex_addr;
      s0_next.data  = ex_wdata;
    end
  end

  // Writeback pipeline shifts every cycle with no stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      s0 <= s0_next;
      s1 <= s0;
      s2 <= s1;
    end
  end

  // Scoreboard next state: a clear then a set, so a same-address set wins; the count saturates at 0.
  always_comb begin
    mask_next = pend_mask;
    cnt_next  = pend_cnt;
    if (lsu_valid) mask_next[lsu_addr] = 1'b0;
    if (set_en) begin
      mask_next[pend_addr] = 1'b1;
      cnt_next = cnt_next + 4'd1;
    end
    if (lsu_valid && (pend_cnt != 4'd0)) cnt_next = cnt_next - 4'd1;
    mask_next[0] = 1'b0;
  end

  // Scoreboard registers and the sticky protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_mask <= '0;
      pend_cnt  <= '0;
      pend_err  <= 1'b0;
    end else begin
      pend_mask <= mask_next;
      pend_cnt  <= cnt_next;
      if (lsu_err) pend_err <= 1'b1;
    end
  end

  assign rs1_busy = pend_mask[rs1_addr] && (rs1_addr != 5'd0);
  assign rs2_busy = pend_mask[rs2_addr] && (rs2_addr != 5'd0);
  assign rs3_busy = pend_mask[rs3_addr] && (rs3_addr != 5'd0);

  // The reader matches on a nonzero address alone, so idle stages must drive zeros.
  assign fwd_0_wen   = s0.valid;
  assign fwd_0_addr  = s0.valid ? s0.addr : 5'd0;
  assign fwd_0_wdata = s0.valid ? s0.data : 32'd0;
  assign fwd_1_wen   = s1.valid;
  assign fwd_1_addr  = s1.valid ? s1.addr : 5'd0;
  assign fwd_1_wdata = s1.valid ? s1.data : 32'd0;
  assign rd_wen      = s2.valid;
  assign rd_addr     = s2.valid ? s2.addr : 5'd0;
  assign rd_wdata    = s2.valid ? s2.data : 32'd0;

endmodule

// File: tb/tb_xc_rf_wb_ctrl.sv
// Testbench for xc_rf_wb_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model. The model holds the pipeline as a
// queue of expected stage outputs and the scoreboard as a bit array and an
// integer count.
module tb_xc_rf_wb_ctrl;

  localparam int MAX_PEND = 4;

  logic        clock, reset;
  logic        ex_valid, ex_ready, ex_wen;
  logic [4:0]  ex_addr;
  logic [31:0] ex_wdata;
  logic        pend_set, pend_ready;
  logic [4:0]  pend_addr;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        fwd_0_wen, fwd_1_wen, rd_wen;
  logic [4:0]  fwd_0_addr, fwd_1_addr, rd_addr;
  logic [31:0] fwd_0_wdata, fwd_1_wdata, rd_wdata;
  logic        pend_err;

  xc_rf_wb_ctrl #(.MAX_PEND(MAX_PEND)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_ready(pend_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
    .fwd_0_wen(fwd_0_wen), .fwd_0_addr(fwd_0_addr), .fwd_0_wdata(fwd_0_wdata),
    .fwd_1_wen(fwd_1_wen), .fwd_1_addr(fwd_1_addr), .fwd_1_wdata(fwd_1_wdata),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .pend_err(pend_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard / model state ----------------
  int          n_vec;
  int          n_err;
  logic [37:0] exp_q[$];  // {wen, addr, wdata} expected on fwd_0, fwd_1, rd
  bit          m_pend[32];
  int          m_cnt;
  bit          m_err;

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(38'd0);
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ex_valid = 0; ex_wen = 0; ex_addr = 0; ex_wdata = 0;
    pend_set = 0; pend_addr = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_wdata = 0;
    rs1_addr = 0; rs2_addr = 0; rs3_addr = 0;
  endtask

  task automatic drive_ex(input logic wen, input logic [4:0] a, input logic [31:0] d);
    ex_valid = 1; ex_wen = wen; ex_addr = a; ex_wdata = d;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid = 1; lsu_addr = a; lsu_wdata = d;
  endtask

  task automatic drive_pend(input logic [4:0] a);
    pend_set = 1; pend_addr = a;
  endtask

  // Check the combinational outputs for the current inputs, advance the model
  // by one edge, clock the DUT, then check the registered outputs.
  task automatic step();
    logic [37:0] ent;
    logic [37:0] act [3];
    bit          acc_set;
    bit          exp_busy [3];
    logic [4:0]  rs [3];
    logic        got_busy [3];
    #1;
    n_vec++;
    if (ex_ready !== (lsu_valid == 1'b0)) begin
      n_err++;
      $display("FAIL ex_ready got %b exp %b", ex_ready, (lsu_valid == 1'b0));
    end
    n_vec++;
    if (pend_ready !== (m_cnt < MAX_PEND)) begin
      n_err++;
      $display("FAIL pend_ready got %b exp %b (model count %0d)", pend_ready, (m_cnt < MAX_PEND), m_cnt);
    end
    rs[0] = rs1_addr; rs[1] = rs2_addr; rs[2] = rs3_addr;
    got_busy[0] = rs1_busy; got_busy[1] = rs2_busy; got_busy[2] = rs3_busy;
    for (int i = 0; i < 3; i++) begin
      exp_busy[i] = m_pend[rs[i]] && (rs[i] != 0);
      n_vec++;
      if (got_busy[i] !== exp_busy[i]) begin
        n_err++;
        $display("FAIL rs%0d_busy addr %0d got %b exp %b", i + 1, rs[i], got_busy[i], exp_busy[i]);
      end
    end

    ent = 38'd0;
    if (lsu_valid) begin
      if (lsu_addr != 0) ent = {1'b1, lsu_addr, lsu_wdata};
    end else if (ex_valid && ex_wen && ex_addr != 0) begin
      ent = {1'b1, ex_addr, ex_wdata};
    end
    exp_q.push_front(ent);
    void'(exp_q.pop_back());

    acc_set = pend_set && (m_cnt < MAX_PEND) && (pend_addr != 0);
    if (lsu_valid) begin
      if (m_cnt == 0 || !m_pend[lsu_addr]) m_err = 1'b1;
      m_pend[lsu_addr] = 1'b0;
      if (m_cnt > 0) m_cnt--;
    end
    if (acc_set) begin
      m_pend[pend_addr] = 1'b1;
      m_cnt++;
    end

    @(posedge clock);
    #1;
    act[0] = {fwd_0_wen, fwd_0_addr, fwd_0_wdata};
    act[1] = {fwd_1_wen, fwd_1_addr, fwd_1_wdata};
    act[2] = {rd_wen, rd_addr, rd_wdata};
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (act[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stage%0d got wen=%b addr=%0d data=%h exp wen=%b addr=%0d data=%h",
                 i, act[i][37], act[i][36:32], act[i][31:0],
                 exp_q[i][37], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    n_vec++;
    if (pend_err !== m_err) begin
      n_err++;
      $display("FAIL pend_err got %b exp %b", pend_err, m_err);
    end
  endtask

  // Reset is asserted away from any clock edge and checked before the next edge.
  task automatic test_reset();
    reset = 1'b1;
    #2;
    model_clear();
    n_vec++;
    if ({fwd_0_wen, fwd_0_addr, fwd_0_wdata, fwd_1_wen, fwd_1_addr, fwd_1_wdata,
         rd_wen, rd_addr, rd_wdata} !== 114'd0) begin
      n_err++;
      $display("FAIL reset_stages got fwd0=%0d/%h fwd1=%0d/%h rd=%0d/%h exp all zero",
               fwd_0_addr, fwd_0_wdata, fwd_1_addr, fwd_1_wdata, rd_addr, rd_wdata);
    end
    n_vec++;
    if ({pend_err, pend_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_sb got err=%b ready=%b exp err=0 ready=1", pend_err, pend_ready);
    end
    drive_idle();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_ex_basic();
    drive_ex(1, 5'd5, 32'hDEADBEEF);
    step();
    drive_idle();
    repeat (4) step();
  endtask

  task automatic test_x0_write();
    drive_ex(1, 5'd0, 32'h1234);
    step();
    drive_idle();
    repeat (3) step();
  endtask

  task automatic test_lsu_priority();
    drive_pend(5'd7);
    step();
    drive_idle();
    rs1_addr = 5'd7;
    repeat (3) step();
    drive_lsu(5'd7, 32'hA5A5A5A5);
    drive_ex(1, 5'd9, 32'h99);
    rs1_addr = 5'd7;
    step();
    lsu_valid = 0;
    step();
    drive_idle();
    rs1_addr = 5'd7;
    repeat (3) step();
  endtask

  task automatic test_full_scoreboard();
    for (int i = 1; i <= 4; i++) begin
      drive_idle();
      drive_pend(5'(i));
      step();
    end
    drive_idle();
    drive_pend(5'd5);
    rs1_addr = 5'd1;
    step();
    drive_idle();
    rs2_addr = 5'd5;
    rs3_addr = 5'd4;
    drive_lsu(5'd2, 32'h22);
    step();
    drive_idle();
    rs1_addr = 5'd2;
    step();
  endtask

  task automatic test_same_cycle_set_clear();
    drive_idle();
    drive_lsu(5'd3, 32'h33);
    drive_pend(5'd3);
    step();
    drive_idle();
    rs1_addr = 5'd3;
    step();
    // Drain the remaining pending writes (x1, x3, x4).
    drive_lsu(5'd1, 32'h11);  step();
    drive_lsu(5'd3, 32'h333); step();
    drive_lsu(5'd4, 32'h44);  step();
    drive_idle();
    rs1_addr = 5'd3;
    repeat (3) step();
  endtask

  task automatic test_err_and_async_reset();
    drive_idle();
    drive_lsu(5'd6, 32'h6);
    step();
    drive_idle();
    repeat (4) step();
    drive_ex(1, 5'd12, 32'hCAFE0001);
    step();
    drive_ex(1, 5'd13, 32'hCAFE0002);
    step();
    drive_idle();
    #2;
    test_reset();
    repeat (2) step();
  endtask

  task automatic test_random();
    int list[$];
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      if ($urandom_range(0, 1) == 1) begin
        drive_ex(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) drive_pend(5'($urandom_range(0, 31)));
      list.delete();
      for (int i = 1; i < 32; i++) if (m_pend[i]) list.push_back(i);
      if (m_cnt > 0 && list.size() > 0 && $urandom_range(0, 2) == 0) begin
        drive_lsu(5'(list[$urandom_range(0, list.size() - 1)]), $urandom);
        if ($urandom_range(0, 3) == 0) drive_pend(lsu_addr);
      end
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = (list.size() > 0) ? 5'(list[0]) : 5'd0;
      rs3_addr = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    drive_idle();
    model_clear();
    reset = 1'b0;
    #3;
    test_reset();
    test_ex_basic();
    test_x0_write();
    test_lsu_priority();
    test_full_scoreboard();
    test_same_cycle_set_clear();
    test_err_and_async_reset();
    test_reset();
    test_random();
    drive_idle();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xc_rf_wb_ctrl.md
Name: xc_rf_wb_ctrl

Overview:
- Write-side producer for the forwarding 3-read register file.
- Accepts results from the execute unit (valid/ready) and from the long-latency load/coprocessor path, merges them into one 3-stage writeback pipeline, and drives the fwd_0, fwd_1 and rd write ports.
- Keeps a pending-write scoreboard so issue logic can stall on source registers whose values are not yet produced.

Parameters:
- MAX_PEND, 4, maximum number of outstanding long-latency writes; legal range 1..15.

Ports:
- clock  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous active-high reset
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted this cycle when ex_valid && ex_ready
- ex_wen  in  1  execute result writes a register
- ex_addr  in  5  execute destination
- ex_wdata  in  32  execute result
- pend_set  in  1  long-latency op issued, destination pend_addr
- pend_addr  in  5  destination of issued long-latency op
- pend_ready  out  1  scoreboard can accept pend_set
- lsu_valid  in  1  long-latency result returns; cannot be stalled
- lsu_addr  in  5  returning destination
- lsu_wdata  in  32  returning data
- rs1_addr, rs2_addr, rs3_addr  in  5 each  issue-stage source queries
- rs1_busy, rs2_busy, rs3_busy  out  1 each  source has an outstanding long-latency write
- fwd_0_wen, fwd_0_addr, fwd_0_wdata  out  1/5/32  stage S0 contents
- fwd_1_wen, fwd_1_addr, fwd_1_wdata  out  1/5/32  stage S1 contents
- rd_wen, rd_addr, rd_wdata  out  1/5/32  stage S2 contents; regfile write port
- pend_err  out  1  sticky protocol error

Behaviour:
- Reset: all stage valid/addr/data = 0, scoreboard = 0, outstanding count = 0, pend_err = 0. Consequently all *_wen/*_addr/*_wdata = 0, pend_ready = 1 and all busy = 0.
- Reset asserted mid-operation discards every stage and all scoreboard state immediately; no writes are emitted.
- Pipeline S0 -> S1 -> S2 shifts every cycle with no stall. Each stage holds {valid, addr, data}.
- Entry into S0 is chosen each cycle:
  - If lsu_valid: lsu_addr/lsu_wdata enter S0.
  - Else if ex_valid && ex_wen: ex_addr/ex_wdata enter S0.
  - Else S0 becomes invalid.
  - ex_valid && !ex_wen is accepted and consumed, and S0 becomes invalid.
- ex_ready = !lsu_valid (combinational). The LSU path always wins arbitration.
- A write to address 0 enters S0 as invalid.
- Output gating:
  - Stage outputs: wen = valid; addr = valid ? addr : 0; wdata = valid ? data : 0.
  - Forced zeros are mandatory because the reader matches on nonzero address alone and ignores wen.
- Latency: a result accepted at edge k appears on fwd_0 during cycle k+1, on fwd_1 during k+2, and on rd during k+3, then leaves the pipeline.
- Scoreboard: 32-bit pending mask; bit 0 is never set.
  - pend_set && pend_ready && pend_addr != 0 sets bit[pend_addr] and increments the count.
  - pend_set with pend_addr = 0 is ignored and does not change the count.
  - lsu_valid clears bit[lsu_addr] and decrements the count.
- Simultaneous set and clear of the same address: set wins (bit stays 1); the count is unchanged net.
- pend_ready = (count < MAX_PEND), combinational from registered count. pend_set while !pend_ready is ignored.
- Busy: rsN_busy = mask[rsN_addr] && (rsN_addr != 0), combinational. Busy drops the cycle after the lsu_valid edge, when the data is already visible on fwd_0.
- Errors set pend_err (held until reset); the count saturates at 0:
  - lsu_valid while count = 0, or
  - lsu_valid with lsu_addr whose mask bit is 0.
- The count is 4 bits wide.

Test Plan:
- Reset then ex_valid=1, ex_wen=1, ex_addr=5, ex_wdata=0xDEADBEEF for one cycle -> fwd_0 shows {1,5,0xDEADBEEF} in cycle 1, fwd_1 in cycle 2, rd in cycle 3; all other cycles show {0,0,0}.
- ex write to x0 with data 0x1234 -> fwd_0/fwd_1/rd stay {0,0,0} throughout; ex_ready=1.
- pend_set x7, then 3 idle cycles, then lsu_valid x7 data 0xA5A5A5A5 while ex_valid offers x9 -> ex_ready=0 that cycle, fwd_0={1,7,0xA5A5A5A5} next cycle, x9 is accepted the following cycle; rs1_addr=7 gives busy=1 until the lsu edge, then 0.
- Issue pend_set to x1..x4 (MAX_PEND=4) -> pend_ready=0; a pend_set to x5 is ignored (rs_busy for x5 = 0); lsu_valid x2 -> pend_ready=1 next cycle.
- Same cycle: lsu_valid x3 while pend_set x3 (x3 pending) -> x3 stays busy, count unchanged, pend_err=0.
- lsu_valid x6 with empty scoreboard -> pend_err=1 and held, count stays 0; data 0x6 still flows fwd_0 -> rd. Asserting reset mid-pipeline clears all outputs and pend_err asynchronously.
